// File: rtl/aes_key_pkg.sv
// Shared types and sizes for the AES-128 round-key buffer.
// Slot count is NUM_ROUNDS+1; each slot is four 32-bit key words.
package aes_key_pkg;

    localparam int ROUND_KEY_W   = 128;
    localparam int NUM_ROUNDS    = 10;
    localparam int NUM_KEY_WORDS = 44;
    localparam int NUM_SLOTS     = NUM_ROUNDS + 1;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        READY,
        STREAM
    } rkb_state_t;

    typedef logic [ROUND_KEY_W-1:0] round_key_t;

endpackage

// File: rtl/round_key_buffer_if.sv
// Round-key replay handshake towards the cipher datapath.
// The buffer is the master; the datapath drives rnd_key_rdy.
interface round_key_buffer_if;
    import aes_key_pkg::*;

    round_key_t  rnd_key;
    logic        rnd_key_vld;
    logic        rnd_key_rdy;
    logic [3:0]  rnd_key_idx;
    logic        rnd_key_last;

    modport master (
        output rnd_key,
        output rnd_key_vld,
        output rnd_key_idx,
        output rnd_key_last,
        input  rnd_key_rdy
    );

    modport slave (
        input  rnd_key,
        input  rnd_key_vld,
        input  rnd_key_idx,
        input  rnd_key_last,
        output rnd_key_rdy
    );
endinterface

// File: rtl/round_key_rf.sv
// 11 x 128-bit round-key storage with 32-bit lane writes.
// Lane 0 is the most significant word; one combinational read port.
module round_key_rf
    import aes_key_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [3:0]        waddr,
    input  logic [1:0]        wlane,
    input  logic [WORD_W-1:0] wdata,
    input  logic [3:0]        raddr,
    output round_key_t        rdata
);

    round_key_t mem [NUM_SLOTS];

    // Lane write into the addressed slot; reset clears all slots.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (int'(waddr) < NUM_SLOTS)) begin
            mem[waddr][(3 - int'(wlane)) * WORD_W +: WORD_W] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/round_key_buffer.sv
// Captures the 44 expanded key words and replays them as round keys,
// forward for encryption or reverse for decryption.
module round_key_buffer
    import aes_key_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int NUM_ROUNDS = 10,
    parameter int NUM_WORDS  = 44
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 key_in_vld,
    input  logic [WORD_W-1:0]    rnd_word_key_val,
    input  logic                 rnd_word_key_val_vld,
    input  logic                 rd_start,
    input  logic                 rd_decrypt,
    round_key_buffer_if.master   rk,
    output logic                 keys_ready,
    output logic                 overflow
);

    localparam logic [5:0] LAST_WC = 6'(NUM_WORDS - 1);
    localparam logic [5:0] FULL_WC = 6'(NUM_WORDS);
    localparam logic [3:0] TOP_PTR = 4'(NUM_ROUNDS);

    rkb_state_t  state_q, state_d;
    logic [5:0]  wc_q, wc_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        dir_q, dir_d;
    logic        ovf_q, ovf_d;
    logic        we;
    logic [3:0]  waddr;
    logic [1:0]  wlane;
    round_key_t  slot_key;
    logic        vld;
    logic        last;
    logic        hs;

    round_key_rf #(.WORD_W(WORD_W)) u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .wlane (wlane),
        .wdata (rnd_word_key_val),
        .raddr (ptr_q),
        .rdata (slot_key)
    );

    assign vld  = (state_q == STREAM);
    assign last = vld && (dir_q ? (ptr_q == 4'd0) : (ptr_q == TOP_PTR));
    assign hs   = vld && rk.rnd_key_rdy;

    assign rk.rnd_key      = vld ? slot_key : '0;
    assign rk.rnd_key_vld  = vld;
    assign rk.rnd_key_idx  = vld ? ptr_q : 4'd0;
    assign rk.rnd_key_last = last;
    assign keys_ready      = (state_q == READY) || (state_q == STREAM);
    assign overflow        = ovf_q;

    // State, write count, read pointer, direction and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            wc_q    <= '0;
            ptr_q   <= '0;
            dir_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            ptr_q   <= ptr_d;
            dir_q   <= dir_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next state; a new seed key overrides everything else.
    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        ptr_d   = ptr_q;
        dir_d   = dir_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        waddr   = wc_q[5:2];
        wlane   = wc_q[1:0];
        if (key_in_vld) begin
            state_d = FILLING;
            ovf_d   = 1'b0;
            wc_d    = '0;
            if (rnd_word_key_val_vld) begin
                we    = 1'b1;
                waddr = 4'd0;
                wlane = 2'd0;
                wc_d  = 6'd1;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                end
                FILLING: begin
                    if (rnd_word_key_val_vld && (wc_q != FULL_WC)) begin
                        we   = 1'b1;
                        wc_d = wc_q + 6'd1;
                        if (wc_q == LAST_WC) begin
                            state_d = READY;
                        end
                    end
                end
                READY: begin
                    if (rnd_word_key_val_vld) begin
                        ovf_d = 1'b1;
                    end
                    if (rd_start) begin
                        state_d = STREAM;
                        dir_d   = rd_decrypt;
                        ptr_d   = rd_decrypt ? TOP_PTR : 4'd0;
                    end
                end
                STREAM: begin
                    if (rnd_word_key_val_vld) begin
                        ovf_d = 1'b1;
                    end
                    if (hs) begin
                        if (last) begin
                            state_d = READY;
                        end else begin
                            ptr_d = dir_q ? ptr_q - 4'd1 : ptr_q + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
